fpu_divsqrt_seq: RTL and testbench

Parametrised, multi-cycle IEEE-754-style divide / square-root unit. It supplies the FDIV and FSQRT results for the CPU's floating-point path, replacing single-cycle combinational division and the unimplemented square root. It uses a START/BUSY/DONE handshake so the pipeline can stall for the iterative computation. Exponent and mantissa widths are generic, so the same block serves single precision and reduced-precision neuron-model formats.

---
 rtl/fpu_divsqrt_seq_if.sv | 23 ++
 rtl/fpu_divsqrt_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_fpu_divsqrt_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_divsqrt_seq_if.sv
// Request/response bundle of fpu_divsqrt_seq: START/OP/operands towards the unit,
// BUSY/DONE/RESULT and the NV/DZ flags back from it.
interface fpu_divsqrt_seq_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         op;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         exception;
    logic         div_by_zero;

    modport master (output start, op, data1, data2,
                    input  busy, done, result, exception, div_by_zero);
    modport slave  (input  start, op, data1, data2,
                    output busy, done, result, exception, div_by_zero);
endinterface

// File: rtl/fpu_divsqrt_seq.sv
// Multi-cycle divide / square-root unit: restoring iteration one bit per cycle,
// round-toward-zero, special operands answered in a single cycle from IDLE.
module fpu_divsqrt_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fpu_divsqrt_seq_if.slave bus
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned ITER = MAN_W + 2;
    localparam int unsigned RW   = MAN_W + 5;
    localparam int unsigned NW   = 2 * ITER;
    localparam int unsigned CW   = $clog2(ITER + 1);
    localparam int unsigned XW   = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE   = XW'(1);
    localparam logic signed [XW-1:0] ZERO  = '0;
    localparam logic [W-1:0]         QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_NORM} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 op_q, op_d;
    logic                 sign_q, sign_d;
    logic signed [XW-1:0] exp_q, exp_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic [MAN_W:0]       dvs_q, dvs_d;
    logic [NW-1:0]        rad_q, rad_d;
    logic [ITER-1:0]      quo_q, quo_d;
    logic [W-1:0]         res_q, res_d;
    logic                 nv_q, nv_d;
    logic                 dz_q, dz_d;
    logic                 done_q, done_d;

    logic             s1, s2;
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] f1, f2;
    logic             nan1, nan2, inf1, inf2, zero1, zero2, sq;

    assign {s1, e1, f1} = bus.data1;
    assign {s2, e2, f2} = bus.data2;
    assign nan1  = (&e1) & (|f1);
    assign nan2  = (&e2) & (|f2);
    assign inf1  = (&e1) & ~(|f1);
    assign inf2  = (&e2) & ~(|f2);
    assign zero1 = ~(|e1);
    assign zero2 = ~(|e2);
    assign sq    = s1 ^ s2;

    logic         spec_hit, spec_nv, spec_dz;
    logic [W-1:0] spec_res;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = QNAN;
        spec_nv  = 1'b0;
        spec_dz  = 1'b0;
        if (bus.op) begin
            if (nan1)       spec_res = QNAN;
            else if (zero1) spec_res = {s1, {(W-1){1'b0}}};
            else if (s1)    spec_nv  = 1'b1;
            else if (inf1)  spec_res = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else            spec_hit = 1'b0;
        end else begin
            if (nan1 | nan2)                              spec_res = QNAN;
            else if ((zero1 & zero2) | (inf1 & inf2))     spec_nv  = 1'b1;
            else if (inf1)  spec_res = {sq, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else if (zero2) begin
                spec_res = {sq, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                spec_dz  = 1'b1;
            end
            else if (inf2 | zero1) spec_res = {sq, {(W-1){1'b0}}};
            else                   spec_hit = 1'b0;
        end
    end

    // Odd square-root exponents move one factor of two into the significand.
    logic signed [XW-1:0] ediv, eraw, esq;
    logic [MAN_W+1:0]     sqsig;

    always_comb begin
        ediv  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS;
        eraw  = $signed({2'b00, e1}) - BIAS;
        sqsig = eraw[0] ? {1'b1, f1, 1'b0} : {2'b01, f1};
        esq   = ((eraw - $signed({{(XW-1){1'b0}}, eraw[0]})) >>> 1) + BIAS;
    end

    logic [RW-1:0] dv_trial, sq_rem, sq_trial;
    logic          dv_ge, sq_ge;

    assign dv_trial = {{(RW-MAN_W-1){1'b0}}, dvs_q};
    assign dv_ge    = rem_q >= dv_trial;
    assign sq_rem   = {rem_q[RW-3:0], rad_q[NW-1 -: 2]};
    assign sq_trial = {{(RW-ITER-2){1'b0}}, quo_q, 2'b01};
    assign sq_ge    = sq_rem >= sq_trial;

    logic signed [XW-1:0] e_n;
    logic [MAN_W-1:0]     m_n;
    logic [W-1:0]         packed_res;

    always_comb begin
        e_n = quo_q[ITER-1] ? exp_q : exp_q - ONE;
        m_n = quo_q[ITER-1] ? quo_q[ITER-2:1] : quo_q[ITER-3:0];
        if (e_n >= EMAX)
            packed_res = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        else if (e_n <= ZERO)
            packed_res = {sign_q, {(W-1){1'b0}}};
        else
            packed_res = {sign_q, e_n[EXP_W-1:0], m_n};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start && !spec_hit) state_d = S_CALC;
            S_CALC:  if (cnt_q == CW'(1))         state_d = S_NORM;
            S_NORM:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        sign_d = sign_q;
        exp_d  = exp_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        rad_d  = rad_q;
        quo_d  = quo_q;
        res_d  = res_q;
        nv_d   = nv_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                if (spec_hit) begin
                    res_d  = spec_res;
                    nv_d   = spec_nv;
                    dz_d   = spec_dz;
                    done_d = 1'b1;
                end else begin
                    cnt_d = CW'(ITER);
                    op_d  = bus.op;
                    quo_d = '0;
                    if (bus.op) begin
                        sign_d = 1'b0;
                        exp_d  = esq;
                        rem_d  = '0;
                        rad_d  = {sqsig, {(MAN_W+2){1'b0}}};
                    end else begin
                        sign_d = sq;
                        exp_d  = ediv;
                        rem_d  = {{(RW-MAN_W-1){1'b0}}, 1'b1, f1};
                        dvs_d  = {1'b1, f2};
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q) begin
                    quo_d = {quo_q[ITER-2:0], sq_ge};
                    rem_d = sq_ge ? sq_rem - sq_trial : sq_rem;
                    rad_d = rad_q << 2;
                end else begin
                    quo_d = {quo_q[ITER-2:0], dv_ge};
                    rem_d = (dv_ge ? rem_q - dv_trial : rem_q) << 1;
                end
            end
            S_NORM: begin
                res_d  = packed_res;
                nv_d   = 1'b0;
                dz_d   = 1'b0;
                done_d = 1'b1;
            end
            default: done_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            op_q   <= 1'b0;
            sign_q <= 1'b0;
            exp_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            rad_q  <= '0;
            quo_q  <= '0;
            res_q  <= '0;
            nv_q   <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            sign_q <= sign_d;
            exp_q  <= exp_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            rad_q  <= rad_d;
            quo_q  <= quo_d;
            res_q  <= res_d;
            nv_q   <= nv_d;
            dz_q   <= dz_d;
            done_q <= done_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.result      = res_q;
    assign bus.exception   = nv_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_fpu_divsqrt_seq.sv
// Directed scoreboard bench for fpu_divsqrt_seq: single-precision and half-precision
// instances share clock/reset; one stimulus port set is steered to either by sel.
module tb_fpu_divsqrt_seq;
    localparam int unsigned SP_LAT = 26;
    localparam int unsigned HP_LAT = 13;

    typedef struct {
        logic [31:0] res;
        logic        nv;
        logic        dz;
        int unsigned acc;
        int unsigned lat;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    logic        sel = 1'b0;
    logic        start_r = 1'b0;
    logic        op_r = 1'b0;
    logic [31:0] d1_r = '0;
    logic [31:0] d2_r = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_divsqrt_seq_if #(.EXP_W(8), .MAN_W(23)) bs ();
    fpu_divsqrt_seq_if #(.EXP_W(5), .MAN_W(10)) bh ();

    assign bs.start = start_r & ~sel;
    assign bs.op    = op_r;
    assign bs.data1 = d1_r;
    assign bs.data2 = d2_r;
    assign bh.start = start_r & sel;
    assign bh.op    = op_r;
    assign bh.data1 = d1_r[15:0];
    assign bh.data2 = d2_r[15:0];

    fpu_divsqrt_seq #(.EXP_W(8), .MAN_W(23)) u_sp (.clk_i(clk), .rst_i(rst), .bus(bs));
    fpu_divsqrt_seq #(.EXP_W(5), .MAN_W(10)) u_hp (.clk_i(clk), .rst_i(rst), .bus(bh));

    logic [31:0] res_o;
    logic        done_o, busy_o, nv_o, dz_o;
    assign res_o  = sel ? {16'h0000, bh.result} : bs.result;
    assign done_o = sel ? bh.done : bs.done;
    assign busy_o = sel ? bh.busy : bs.busy;
    assign nv_o   = sel ? bh.exception : bs.exception;
    assign dz_o   = sel ? bh.div_by_zero : bs.div_by_zero;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Called on a falling edge; the start is accepted on the next rising edge.
    task automatic launch(input logic s, input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic nv, input logic dz,
                          input int unsigned lat, input string tag);
        exp_t e;
        sel = s; op_r = op; d1_r = a; d2_r = b; start_r = 1'b1;
        e.res = er; e.nv = nv; e.dz = dz; e.acc = cyc + 1; e.lat = lat; e.tag = tag;
        sb.push_back(e);
        @(posedge clk); #1;
        start_r = 1'b0;
    endtask

    task automatic collect();
        exp_t        e;
        int unsigned n = 0;
        @(negedge clk);
        while (done_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", sb.size());
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".done"},   32'(done_o), 32'd1);
        chk({e.tag, ".edge"},   cyc - e.acc, e.lat);
        chk({e.tag, ".busy"},   32'(busy_o), 32'd0);
        chk({e.tag, ".result"}, res_o, e.res);
        chk({e.tag, ".flags"},  32'({nv_o, dz_o}), 32'({e.nv, e.dz}));
    endtask

    task automatic run(input logic s, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic nv, input logic dz,
                       input int unsigned lat, input string tag);
        launch(s, op, a, b, er, nv, dz, lat, tag);
        collect();
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(done_o), 32'd0);
    endtask

    task automatic quiet(input int unsigned n, input string tag);
        int unsigned seen = 0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen++;
        end
        chk(tag, seen, 32'd0);
    endtask

    task automatic hs_test(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                           input logic [31:0] a2, input logic [31:0] b2, input logic [31:0] r2,
                           input int unsigned lat, input string tag);
        launch(s, 1'b0, a, b, r, 1'b0, 1'b0, lat, {tag, ".first"});
        repeat (4) @(negedge clk);
        op_r = 1'b1; d1_r = a2; d2_r = b2; start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        chk({tag, ".busy_ign"}, 32'(busy_o), 32'd1);
        collect();
        quiet(lat + 4, {tag, ".no_extra"});
        launch(s, 1'b0, a2, b2, r2, 1'b0, 1'b0, lat, {tag, ".a"});
        collect();
        launch(s, 1'b0, a, b, r, 1'b0, 1'b0, lat, {tag, ".b2b"});
        collect();
        @(negedge clk);
        chk({tag, ".b2b_pulse"}, 32'(done_o), 32'd0);
    endtask

    task automatic rst_test(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input int unsigned lat, input string tag);
        sel = s; op_r = 1'b0; d1_r = a; d2_r = b; start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        repeat (9) @(negedge clk);
        chk({tag, ".busy_mid"}, 32'(busy_o), 32'd1);
        rst = 1'b1; d2_r = '0; start_r = 1'b1;
        @(negedge clk);
        chk({tag, ".result"}, res_o, 32'd0);
        chk({tag, ".status"}, 32'({busy_o, done_o, nv_o, dz_o}), 32'd0);
        rst = 1'b0; start_r = 1'b0;
        quiet(lat + 4, {tag, ".no_done"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        sel = 1'b0; #1;
        chk("sp_reset.result", res_o, 32'd0);
        chk("sp_reset.status", 32'({busy_o, done_o, nv_o, dz_o}), 32'd0);
        sel = 1'b1; #1;
        chk("hp_reset.result", res_o, 32'd0);
        chk("hp_reset.status", 32'({busy_o, done_o, nv_o, dz_o}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(0, 0, 32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, SP_LAT, "sp_6div2");
        run(0, 0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 0, SP_LAT, "sp_1div3");
        run(0, 0, 32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 0, SP_LAT, "sp_neg");
        run(0, 1, 32'h40000000, 32'hDEADBEEF, 32'h3FB504F3, 0, 0, SP_LAT, "sp_sqrt2");
        run(0, 1, 32'h41000000, 32'h00000000, 32'h403504F3, 0, 0, SP_LAT, "sp_sqrt8");
        run(0, 1, 32'h3F800000, 32'h00000000, 32'h3F800000, 0, 0, SP_LAT, "sp_sqrt1");
        run(0, 0, 32'h7F000000, 32'h3E800000, 32'h7F7FFFFF, 0, 0, SP_LAT, "sp_ovf");
        run(0, 0, 32'h00800000, 32'h4B000000, 32'h00000000, 0, 0, SP_LAT, "sp_unf");
        run(0, 0, 32'h80800000, 32'h4B000000, 32'h80000000, 0, 0, SP_LAT, "sp_unf_neg");
        run(0, 0, 32'h3F800000, 32'h00000000, 32'h7F800000, 0, 1, 0, "sp_dz");
        run(0, 0, 32'h3F800000, 32'h00000001, 32'h7F800000, 0, 1, 0, "sp_dz_denorm");
        run(0, 1, 32'hC0800000, 32'h00000000, 32'h7FC00000, 1, 0, 0, "sp_sqrt_neg");
        run(0, 1, 32'hFF800000, 32'h00000000, 32'h7FC00000, 1, 0, 0, "sp_sqrt_ninf");
        run(0, 1, 32'h80000000, 32'h00000000, 32'h80000000, 0, 0, 0, "sp_sqrt_nzero");
        run(0, 1, 32'h7F800000, 32'h00000000, 32'h7F800000, 0, 0, 0, "sp_sqrt_inf");
        run(0, 0, 32'h00000000, 32'h00000000, 32'h7FC00000, 1, 0, 0, "sp_0div0");
        run(0, 0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1, 0, 0, "sp_infdivinf");
        run(0, 0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 0, 0, 0, "sp_nan");
        run(0, 0, 32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 0, "sp_infdiv");
        run(0, 0, 32'hC0000000, 32'h7F800000, 32'h80000000, 0, 0, 0, "sp_divinf");
        run(0, 0, 32'h80000000, 32'h40000000, 32'h80000000, 0, 0, 0, "sp_zerodiv");
        run(0, 0, 32'h00000001, 32'h3F800000, 32'h00000000, 0, 0, 0, "sp_denorm");
        hs_test(0, 32'h40C00000, 32'h40000000, 32'h40400000,
                32'h3F800000, 32'h40400000, 32'h3EAAAAAA, SP_LAT, "sp_hs");
        rst_test(0, 32'h40C00000, 32'h40000000, SP_LAT, "sp_rst");
        run(0, 0, 32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, SP_LAT, "sp_after_rst");

        run(1, 0, 32'h4600, 32'h4000, 32'h4200, 0, 0, HP_LAT, "hp_6div2");
        run(1, 0, 32'h3C00, 32'h4200, 32'h3555, 0, 0, HP_LAT, "hp_1div3");
        run(1, 1, 32'h4000, 32'hBEEF, 32'h3DA8, 0, 0, HP_LAT, "hp_sqrt2");
        run(1, 1, 32'h4800, 32'h0000, 32'h41A8, 0, 0, HP_LAT, "hp_sqrt8");
        run(1, 0, 32'h7800, 32'h3400, 32'h7BFF, 0, 0, HP_LAT, "hp_ovf");
        run(1, 0, 32'h0400, 32'h6400, 32'h0000, 0, 0, HP_LAT, "hp_unf");
        run(1, 0, 32'h3C00, 32'h0000, 32'h7C00, 0, 1, 0, "hp_dz");
        run(1, 1, 32'hC400, 32'h0000, 32'h7E00, 1, 0, 0, "hp_sqrt_neg");
        run(1, 0, 32'h0000, 32'h0000, 32'h7E00, 1, 0, 0, "hp_0div0");
        run(1, 0, 32'h0001, 32'h3C00, 32'h0000, 0, 0, 0, "hp_denorm");
        hs_test(1, 32'h4600, 32'h4000, 32'h4200, 32'h3C00, 32'h4200, 32'h3555, HP_LAT, "hp_hs");
        rst_test(1, 32'h4600, 32'h4000, HP_LAT, "hp_rst");
        run(1, 0, 32'h4600, 32'h4000, 32'h4200, 0, 0, HP_LAT, "hp_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
